// File: rtl/mac_operand_feeder.sv
// Operand buffer/streamer feeding one MAC input via the waiting/ready/finished handshake.
// Optional REPLAY_EN: keeps the vector after a stream for replay and adds a buf_clear input.
module mac_operand_feeder #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             start,
`ifdef REPLAY_EN
  input  logic             buf_clear,
`endif
  output logic [WIDTH-1:0] out_data,
  output logic             out_waiting,
  output logic             out_finished,
  input  logic             in_ready,
  output logic             busy,
  output logic [LVL_W-1:0] level
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESENT,
    S_HOLD,
    S_DONE,
    S_DRAIN
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_buf [DEPTH];
  logic [AW-1:0]    r_wr_ptr, w_wr_ptr_nxt;
  logic [AW-1:0]    r_rd_ptr, w_rd_ptr_nxt, w_rd_inc;
  logic [LVL_W-1:0] r_level, w_level_nxt;
  logic [WIDTH-1:0] r_out_data, w_out_data_nxt;
  logic             r_waiting, w_waiting_nxt;
  logic             r_finished, w_finished_nxt;
  logic             r_busy;
  logic             w_write, w_clear, w_last;

  assign load_ready = (r_state == S_IDLE) && (r_level < LVL_W'(DEPTH));

`ifdef REPLAY_EN
  assign w_clear = (r_state == S_IDLE) && buf_clear;
`else
  assign w_clear = 1'b0;
`endif

  assign w_write  = load_valid && load_ready && !w_clear;
  assign w_rd_inc = r_rd_ptr + AW'(1);
  assign w_last   = (LVL_W'(r_rd_ptr) == (r_level - LVL_W'(1)));

  always_comb begin
    w_state_nxt    = r_state;
    w_wr_ptr_nxt   = r_wr_ptr;
    w_rd_ptr_nxt   = r_rd_ptr;
    w_level_nxt    = r_level;
    w_out_data_nxt = r_out_data;
    w_waiting_nxt  = 1'b0;
    w_finished_nxt = 1'b0;

    if (w_clear) begin
      w_level_nxt  = '0;
      w_wr_ptr_nxt = '0;
    end else if (w_write) begin
      w_level_nxt  = r_level + LVL_W'(1);
      w_wr_ptr_nxt = r_wr_ptr + AW'(1);
    end

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_rd_ptr_nxt = '0;
          if (w_level_nxt != '0) begin
            w_state_nxt   = S_PRESENT;
            w_waiting_nxt = 1'b1;
            // A write in the start cycle into an empty buffer is forwarded directly.
            w_out_data_nxt = (r_level == '0) ? load_data : r_buf[0];
          end else begin
            w_state_nxt    = S_DONE;
            w_finished_nxt = 1'b1;
            w_out_data_nxt = '0;
          end
        end
      end
      S_PRESENT: begin
        w_waiting_nxt = 1'b1;
        if (in_ready) begin
          w_state_nxt   = S_HOLD;
          w_waiting_nxt = 1'b0;
        end
      end
      S_HOLD: begin
        w_rd_ptr_nxt = w_rd_inc;
        if (w_last) begin
          w_state_nxt    = S_DONE;
          w_finished_nxt = 1'b1;
          w_out_data_nxt = '0;
        end else begin
          w_state_nxt    = S_PRESENT;
          w_waiting_nxt  = 1'b1;
          w_out_data_nxt = r_buf[w_rd_inc];
        end
      end
      S_DONE: begin
        w_finished_nxt = 1'b1;
        if (in_ready) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_state_nxt = S_IDLE;
`ifndef REPLAY_EN
        w_level_nxt  = '0;
        w_wr_ptr_nxt = '0;
`endif
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_out_data <= '0;
      r_waiting  <= 1'b0;
      r_finished <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_level    <= w_level_nxt;
      r_out_data <= w_out_data_nxt;
      r_waiting  <= w_waiting_nxt;
      r_finished <= w_finished_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (w_write) begin
      r_buf[r_wr_ptr] <= load_data;
    end
  end

  assign out_data     = r_out_data;
  assign out_waiting  = r_waiting;
  assign out_finished = r_finished;
  assign busy         = r_busy;
  assign level        = r_level;

endmodule
